axi_wr_pair_buffer: RTL



---
 rtl/axi_wr_pair_buffer_pkg.sv | 22 ++
 rtl/axi_beat_fifo.sv | 69 ++++++
 rtl/axi_wr_pair_buffer.sv | 100 ++++++++++
 3 files changed

// File: rtl/axi_wr_pair_buffer_pkg.sv
// Shared types and constants for the AXI write pair buffer.
// Default beat layout, drop counter width and a saturating increment.
package axi_wr_pair_buffer_pkg;

  localparam int ADDR = 32;
  localparam int DATA = 32;
  localparam int STRB = 4;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] data;
    logic [STRB-1:0] strb;
  } axiWrPairSt;

  function automatic logic [DROP_CNT_W-1:0] satInc(
    input logic [DROP_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axi_beat_fifo.sv
// Synchronous FIFO with registered ready and occupancy level.
// Pointers carry one extra wrap bit to tell full from empty.
module axi_beat_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pushValid,
  output logic                         pushReady,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         popEn,
  output logic [WIDTH-1:0]             popData,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  generate
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : gBadDepth
      $error("axi_beat_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtrNext;
  logic [PW-1:0]    rdPtrNext;
  logic             push;
  logic             pop;
  logic             fullNext;

  assign empty = (wrPtr == rdPtr);
  assign push  = pushValid && pushReady;
  assign pop   = popEn && !empty;

  assign wrPtrNext = wrPtr + PW'(push);
  assign rdPtrNext = rdPtr + PW'(pop);

  // Ready looks at next-cycle occupancy, so a pop frees a slot one cycle late
  assign fullNext =
    (wrPtrNext[PW-1] != rdPtrNext[PW-1]) &&
    (wrPtrNext[AW-1:0] == rdPtrNext[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      pushReady <= 1'b0;
    end else begin
      wrPtr     <= wrPtrNext;
      rdPtr     <= rdPtrNext;
      pushReady <= !fullNext;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr[AW-1:0]] <= pushData;
    end
  end

  assign popData = mem[rdPtr[AW-1:0]];
  assign level   = wrPtr - rdPtr;

endmodule

// File: rtl/axi_wr_pair_buffer.sv
// Pairs independently queued AW and W beats into one write beat.
// Optionally discards pairs whose strobe is all-zero.
module axi_wr_pair_buffer
  import axi_wr_pair_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR,
  parameter int DATA_WIDTH     = DATA,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int DEPTH          = 4,
  parameter bit DROP_NULL_STRB = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         aw_valid,
  output logic                         aw_ready,
  input  logic [ADDR_WIDTH-1:0]        aw_addr,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic [STRB_WIDTH-1:0]        w_strb,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [STRB_WIDTH-1:0]        out_strb,
  output logic [$clog2(DEPTH+1)-1:0]   aw_level,
  output logic [$clog2(DEPTH+1)-1:0]   w_level,
  output logic [DROP_CNT_W-1:0]        drop_count
);

  localparam int WW = DATA_WIDTH + STRB_WIDTH;

  generate
    if (STRB_WIDTH != DATA_WIDTH / 8 || DATA_WIDTH < 8 ||
        DATA_WIDTH % 8 != 0) begin : gBadWidth
      $error("axi_wr_pair_buffer: bad DATA/STRB width");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] awHead;
  logic [WW-1:0]         wHead;
  logic [STRB_WIDTH-1:0] headStrb;
  logic                  awEmpty;
  logic                  wEmpty;
  logic                  pairAvail;
  logic                  nullHead;
  logic                  dropPop;
  logic                  pop;

  axi_beat_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) uAwFifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushValid (aw_valid),
    .pushReady (aw_ready),
    .pushData  (aw_addr),
    .popEn     (pop),
    .popData   (awHead),
    .empty     (awEmpty),
    .level     (aw_level)
  );

  axi_beat_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) uWFifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushValid (w_valid),
    .pushReady (w_ready),
    .pushData  ({w_data, w_strb}),
    .popEn     (pop),
    .popData   (wHead),
    .empty     (wEmpty),
    .level     (w_level)
  );

  assign headStrb  = wHead[STRB_WIDTH-1:0];
  assign pairAvail = !awEmpty && !wEmpty;
  assign nullHead  = DROP_NULL_STRB && (headStrb == '0);
  assign dropPop   = pairAvail && nullHead;
  assign out_valid = pairAvail && !nullHead;
  assign pop       = (out_valid && out_ready) || dropPop;

  // Fields are masked while idle so the port reads zero out of reset
  assign out_addr = out_valid ? awHead : '0;
  assign out_data = out_valid ? wHead[WW-1:STRB_WIDTH] : '0;
  assign out_strb = out_valid ? headStrb : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (dropPop) begin
      drop_count <= satInc(drop_count);
    end
  end

endmodule
